ob_bank_sched: RTL and testbench
================================

# ob_bank_sched

Outbound bank scheduler for the C2H path. Eight 128-bit staging RAM banks each signal "full" independently. This block picks one full bank at a time using round-robin. It hands the bank's base address and length to the outbound streamer over a req/ack/done handshake, releases the bank back to the producer once the transfer completes, and raises one user interrupt per drained bank, mapped onto the MSI vectors currently enabled.

## Interface
Parameters:
- NUM_BANKS, 8, number of staging banks (power of two).
- BANK_WORDS, 256, 128-bit words per bank; also transfer length.
- ADDR_W, 32, RAM word-address width.
- IRQ_W, 16, user interrupt vector count.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- sched_en  in  1  permits new grants; in-flight transfer always completes.
- DataValid  in  NUM_BANKS  level; bank i full; held by producer until released.
- RamValid  out  NUM_BANKS  one-cycle pulse; bank i drained and returned to producer.
- xfer_req  out  1  grant valid to streamer.
- xfer_bank  out  3  granted bank index.
- xfer_base  out  ADDR_W  xfer_bank * BANK_WORDS.
- xfer_len  out  16  BANK_WORDS.
- xfer_ack  in  1  streamer accepted grant.
- xfer_done  in  1  pulse; last C2H beat of the grant accepted (tlast & tready).
- usr_irq_req  out  IRQ_W  pending interrupt per vector.
- usr_irq_ack  in  IRQ_W  per-vector acknowledge pulse.
- msi_enable  in  1  interrupts generated only when high.
- msi_vector_width  in  3  enabled vectors = 2^n, n>=4 treated as 16.
- busy  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, REQ, XFER, RELEASE.
- IDLE: if sched_en && |DataValid, select the first set bit searching upward from last_grant+1 (mod NUM_BANKS). Register the selection into xfer_bank/xfer_base and go to REQ. Otherwise stay in IDLE.
- REQ: xfer_req=1. Outputs stay stable until xfer_ack. On ack: go to XFER, or go straight to RELEASE if xfer_done is in the same cycle.
- XFER: wait for xfer_done, then go to RELEASE. xfer_done outside REQ/XFER is ignored.
- RELEASE: pulse RamValid[xfer_bank] for one cycle and set last_grant=xfer_bank. If msi_enable, set pending[vec] with vec = xfer_bank & (nvec-1). Then go to IDLE.
- Interrupt pending register is independent of the FSM. usr_irq_req = pending.
  - Ack on a set bit clears it; ack on a clear bit is ignored.
  - Set and ack on the same bit in the same cycle: set wins.
  - Multiple drains to one vector before ack coalesce into one request.
- sched_en low only blocks the IDLE→REQ transition.
- A DataValid drop during REQ/XFER is a protocol violation; the grant still completes.

## Timing
- Reset: FSM=IDLE, last_grant=NUM_BANKS-1 (bank 0 has first priority), pending=0. All outputs are 0 except xfer_len=BANK_WORDS.
- Grant latency: DataValid seen in IDLE at cycle t → xfer_req high at t+1.
- Release: xfer_done at t → RamValid pulse at t+1 → IDLE at t+2. The earliest next xfer_req is t+3.
- Interrupt: pending bit rises in the same cycle as the RamValid pulse. The earliest clear is the cycle after the ack.
- Wrap-around: search from bank 7 wraps to bank 0.
- Reset asserted mid-transfer: immediate return to reset values. No RamValid pulse for the aborted bank.

## Structure
- Shared package ob_pkg: NUM_BANKS, BANK_WORDS, the FSM state enum, and a vec_mask(msi_vector_width) function returning nvec-1.
- One sub-module: ob_rr_arb, a combinational round-robin priority picker (req vector, last_grant) → (any, idx). It is reusable by other multi-bank controllers.
- Interrupt pending logic stays inline.

## Test plan
- Single bank: DataValid=8'h04 → xfer_req at +1 with xfer_bank=2 and xfer_base=512. Drive ack at +3 and done at +10 → RamValid=8'h04 pulse at +11. With msi_enable=1 and width=3, usr_irq_req[2]=1 until usr_irq_ack[2].
- Round-robin: DataValid=8'hFF held and re-asserted → grant order 0,1,…,7,0. No bank is granted twice before all others.
- Vector folding: msi_vector_width=1 (2 vectors), drain banks 3 and 5 without ack → usr_irq_req=16'h0002 (coalesced). Ack bit1 → 0. msi_enable=0 → no request.
- Same-cycle ack+done in REQ → RELEASE next cycle. Set and ack on one vector in the same cycle → bit stays 1.
- sched_en dropped during XFER → current RamValid pulse still issued, no further xfer_req while DataValid=8'hFF. Re-enable → next grant is last_grant+1.
- rst_n asserted during XFER → all outputs 0 asynchronously, no RamValid. After release, DataValid=8'h81 grants bank 0 first.

Source files
------------

// File: rtl/ob_pkg.sv
// Shared definitions for the outbound bank scheduler and related bank controllers.
package ob_pkg;

  localparam int NUM_BANKS  = 8;
  localparam int BANK_WORDS = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Number of enabled MSI vectors minus one; widths of 4 and above cap at 16 vectors.
  function automatic logic [3:0] vec_mask(input logic [2:0] width);
    logic [3:0] m;
    m = 4'hF;
    if (width < 3'd4) m = 4'((5'd1 << width) - 5'd1);
    return m;
  endfunction

endpackage

// File: rtl/ob_rr_arb.sv
// Combinational round-robin picker: the first set request strictly after last_grant, wrapping.
module ob_rr_arb #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] pos;

  // Scan from the farthest offset down to +1 so the nearest request after last_grant wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int i = N; i >= 1; i--) begin
      pos = last_grant + IW'(i);
      if (req[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/ob_bank_sched.sv
// Outbound bank scheduler: round-robin grant of full staging banks to the C2H streamer,
// bank release back to the producer, and one MSI user interrupt per drained bank.
module ob_bank_sched #(
  parameter int NUM_BANKS  = ob_pkg::NUM_BANKS,
  parameter int BANK_WORDS = ob_pkg::BANK_WORDS,
  parameter int ADDR_W     = 32,
  parameter int IRQ_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sched_en,
  input  logic [NUM_BANKS-1:0]         DataValid,
  output logic [NUM_BANKS-1:0]         RamValid,
  output logic                         xfer_req,
  output logic [$clog2(NUM_BANKS)-1:0] xfer_bank,
  output logic [ADDR_W-1:0]            xfer_base,
  output logic [15:0]                  xfer_len,
  input  logic                         xfer_ack,
  input  logic                         xfer_done,
  output logic [IRQ_W-1:0]             usr_irq_req,
  input  logic [IRQ_W-1:0]             usr_irq_ack,
  input  logic                         msi_enable,
  input  logic [2:0]                   msi_vector_width,
  output logic                         busy
);

  import ob_pkg::*;

  localparam int BW = $clog2(NUM_BANKS);
  localparam int VW = $clog2(IRQ_W);

  state_t           state, state_nxt;
  logic [BW-1:0]    bank_q, last_grant;
  logic [ADDR_W-1:0] base_q;
  logic [IRQ_W-1:0] pending, irq_set;
  logic             arb_any;
  logic [BW-1:0]    arb_idx;
  logic [VW-1:0]    vec;
  logic             enter_rel;

  ob_rr_arb #(.N(NUM_BANKS)) u_arb (
    .req        (DataValid),
    .last_grant (last_grant),
    .any        (arb_any),
    .idx        (arb_idx)
  );

  // Next-state logic; sched_en gates only the IDLE->REQ step so an in-flight grant always finishes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sched_en && arb_any) state_nxt = REQ;
      REQ:     if (xfer_ack) state_nxt = xfer_done ? RELEASE : XFER;
      XFER:    if (xfer_done) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched grant and round-robin pointer; bank 0 has first priority out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bank_q     <= '0;
      base_q     <= '0;
      last_grant <= BW'(NUM_BANKS - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == REQ) begin
        bank_q <= arb_idx;
        base_q <= ADDR_W'(arb_idx) * ADDR_W'(BANK_WORDS);
      end
      if (state == RELEASE) last_grant <= bank_q;
    end
  end

  // The pending bit is set on the edge that enters RELEASE so it rises alongside RamValid.
  assign enter_rel = (state_nxt == RELEASE) && (state != RELEASE);
  assign vec       = VW'(32'(bank_q) & 32'(vec_mask(msi_vector_width)));
  assign irq_set   = (enter_rel && msi_enable) ? (IRQ_W'(1) << vec) : '0;

  // Interrupt pending: ack clears, a same-cycle set overrides the ack, repeats coalesce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~usr_irq_ack) | irq_set;
  end

  assign xfer_req    = (state == REQ);
  assign xfer_bank   = bank_q;
  assign xfer_base   = base_q;
  assign xfer_len    = 16'(BANK_WORDS);
  assign busy        = (state != IDLE);
  assign RamValid    = (state == RELEASE) ? (NUM_BANKS'(1) << bank_q) : '0;
  assign usr_irq_req = pending;

endmodule

// File: tb/tb_ob_bank_sched.sv
// Scenario bench for ob_bank_sched: expected grants are queued when banks are filled and
// compared as the scheduler issues them.
module tb_ob_bank_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sched_en = 1'b0;
  logic [7:0]  DataValid = '0;
  logic [7:0]  RamValid;
  logic        xfer_req;
  logic [2:0]  xfer_bank;
  logic [31:0] xfer_base;
  logic [15:0] xfer_len;
  logic        xfer_ack = 1'b0;
  logic        xfer_done = 1'b0;
  logic [15:0] usr_irq_req;
  logic [15:0] usr_irq_ack = '0;
  logic        msi_enable = 1'b0;
  logic [2:0]  msi_vector_width = 3'd3;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  ob_bank_sched dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sched_en         (sched_en),
    .DataValid        (DataValid),
    .RamValid         (RamValid),
    .xfer_req         (xfer_req),
    .xfer_bank        (xfer_bank),
    .xfer_base        (xfer_base),
    .xfer_len         (xfer_len),
    .xfer_ack         (xfer_ack),
    .xfer_done        (xfer_done),
    .usr_irq_req      (usr_irq_req),
    .usr_irq_ack      (usr_irq_ack),
    .msi_enable       (msi_enable),
    .msi_vector_width (msi_vector_width),
    .busy             (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    DataValid = '0;
    xfer_ack = 1'b0;
    xfer_done = 1'b0;
    usr_irq_ack = '0;
    sched_en = 1'b1;
    msi_enable = 1'b0;
    msi_vector_width = 3'd3;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Streamer + producer model: wait for a grant, ack it, finish it, and capture the release.
  task automatic do_grant(input int ack_d, input int done_d, input bit same, input bit drop_en,
                          input logic [15:0] irq_ack_done,
                          output logic [2:0] bank, output logic [31:0] base,
                          output logic [7:0] rv, output bit to);
    to = 1'b0; bank = '0; base = '0; rv = '0;
    for (int i = 0; i < 50 && !xfer_req; i++) tick();
    if (!xfer_req) begin
      to = 1'b1;
      return;
    end
    bank = xfer_bank;
    base = xfer_base;
    repeat (ack_d) tick();
    xfer_ack = 1'b1;
    if (same) begin
      xfer_done = 1'b1;
      usr_irq_ack = irq_ack_done;
    end
    tick();
    xfer_ack = 1'b0;
    xfer_done = 1'b0;
    usr_irq_ack = '0;
    if (!same) begin
      if (drop_en) sched_en = 1'b0;
      repeat (done_d) tick();
      xfer_done = 1'b1;
      usr_irq_ack = irq_ack_done;
      tick();
      xfer_done = 1'b0;
      usr_irq_ack = '0;
    end
    rv = RamValid;
    DataValid = DataValid & ~rv;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (xfer_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", xfer_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (RamValid !== 8'h00) begin errors++; $display("FAIL reset_ramvalid got=%h exp=00", RamValid); end
    checks++; if (xfer_bank !== 3'd0 || xfer_base !== 32'd0) begin errors++; $display("FAIL reset_grant got=%0d/%0d exp=0/0", xfer_bank, xfer_base); end
    checks++; if (xfer_len !== 16'd256) begin errors++; $display("FAIL reset_len got=%0d exp=256", xfer_len); end
    checks++; if (usr_irq_req !== 16'h0000) begin errors++; $display("FAIL reset_irq got=%h exp=0000", usr_irq_req); end
  endtask

  task automatic test_single();
    logic [2:0] b; logic [31:0] base; logic [7:0] rv; bit to; int e;
    apply_reset();
    msi_enable = 1'b1;
    msi_vector_width = 3'd3;
    DataValid = 8'h04;
    exp_q.push_back(2);
    tick();
    checks++; if (xfer_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_latency req=%b busy=%b exp=1/1", xfer_req, busy); end
    checks++; if (xfer_len !== 16'd256) begin errors++; $display("FAIL single_len got=%0d exp=256", xfer_len); end
    do_grant(2, 6, 1'b0, 1'b0, 16'h0, b, base, rv, to);
    e = exp_q.pop_front();
    checks++; if (to) begin errors++; $display("FAIL single_timeout no grant"); end
    checks++; if (b !== 3'(e) || base !== 32'(e * 256)) begin errors++; $display("FAIL single_grant got=%0d/%0d exp=%0d/%0d", b, base, e, e * 256); end
    checks++; if (rv !== 8'(1 << e)) begin errors++; $display("FAIL single_ramvalid got=%h exp=%h", rv, 8'(1 << e)); end
    checks++; if (RamValid !== 8'h00) begin errors++; $display("FAIL single_pulse_width got=%h exp=00", RamValid); end
    tick(); tick();
    checks++; if (usr_irq_req !== 16'h0004) begin errors++; $display("FAIL single_irq got=%h exp=0004", usr_irq_req); end
    usr_irq_ack = 16'h0004;
    tick();
    usr_irq_ack = '0;
    checks++; if (usr_irq_req !== 16'h0000) begin errors++; $display("FAIL single_irq_ack got=%h exp=0000", usr_irq_req); end
  endtask

  task automatic test_round_robin();
    logic [2:0] b; logic [31:0] base; logic [7:0] rv; bit to; int e;
    apply_reset();
    DataValid = 8'hFF;
    for (int k = 0; k < 9; k++) exp_q.push_back(k % 8);
    for (int k = 0; k < 9; k++) begin
      do_grant(1, 2, 1'b0, 1'b0, 16'h0, b, base, rv, to);
      e = exp_q.pop_front();
      checks++; if (to || b !== 3'(e) || rv !== 8'(1 << e)) begin errors++; $display("FAIL rr_order step=%0d got bank=%0d rv=%h exp bank=%0d", k, b, rv, e); end
      DataValid = DataValid | rv;
    end
  endtask

  task automatic test_vector_fold();
    logic [2:0] b; logic [31:0] base; logic [7:0] rv; bit to; int e;
    apply_reset();
    msi_enable = 1'b1;
    msi_vector_width = 3'd1;
    DataValid = 8'h08;
    exp_q.push_back(3);
    do_grant(1, 1, 1'b0, 1'b0, 16'h0, b, base, rv, to);
    e = exp_q.pop_front();
    checks++; if (to || b !== 3'(e)) begin errors++; $display("FAIL fold_grant3 got=%0d exp=%0d", b, e); end
    DataValid = 8'h20;
    exp_q.push_back(5);
    do_grant(1, 1, 1'b0, 1'b0, 16'h0, b, base, rv, to);
    e = exp_q.pop_front();
    checks++; if (to || b !== 3'(e)) begin errors++; $display("FAIL fold_grant5 got=%0d exp=%0d", b, e); end
    checks++; if (usr_irq_req !== 16'h0002) begin errors++; $display("FAIL fold_coalesce got=%h exp=0002", usr_irq_req); end
    usr_irq_ack = 16'h0002;
    tick();
    usr_irq_ack = '0;
    checks++; if (usr_irq_req !== 16'h0000) begin errors++; $display("FAIL fold_ack got=%h exp=0000", usr_irq_req); end
    msi_enable = 1'b0;
    DataValid = 8'h02;
    exp_q.push_back(1);
    do_grant(1, 1, 1'b0, 1'b0, 16'h0, b, base, rv, to);
    e = exp_q.pop_front();
    checks++; if (to || rv !== 8'(1 << e)) begin errors++; $display("FAIL fold_msi_off_drain got=%h exp=%h", rv, 8'(1 << e)); end
    checks++; if (usr_irq_req !== 16'h0000) begin errors++; $display("FAIL fold_msi_off got=%h exp=0000", usr_irq_req); end
  endtask

  task automatic test_same_cycle();
    logic [2:0] b; logic [31:0] base; logic [7:0] rv; bit to; int e;
    apply_reset();
    msi_enable = 1'b1;
    msi_vector_width = 3'd3;
    DataValid = 8'h04;
    exp_q.push_back(2);
    do_grant(1, 0, 1'b1, 1'b0, 16'h0, b, base, rv, to);
    e = exp_q.pop_front();
    checks++; if (to || rv !== 8'(1 << e)) begin errors++; $display("FAIL same_ackdone_release got=%h exp=%h", rv, 8'(1 << e)); end
    checks++; if (usr_irq_req !== 16'h0004) begin errors++; $display("FAIL same_irq_first got=%h exp=0004", usr_irq_req); end
    DataValid = 8'h04;
    exp_q.push_back(2);
    do_grant(0, 3, 1'b0, 1'b0, 16'h0004, b, base, rv, to);
    e = exp_q.pop_front();
    checks++; if (to || b !== 3'(e)) begin errors++; $display("FAIL same_grant2 got=%0d exp=%0d", b, e); end
    checks++; if (usr_irq_req !== 16'h0004) begin errors++; $display("FAIL same_set_wins got=%h exp=0004", usr_irq_req); end
  endtask

  task automatic test_sched_en();
    logic [2:0] b; logic [31:0] base; logic [7:0] rv; bit to; int e; int seen;
    apply_reset();
    DataValid = 8'hFF;
    exp_q.push_back(0);
    do_grant(1, 3, 1'b0, 1'b1, 16'h0, b, base, rv, to);
    e = exp_q.pop_front();
    checks++; if (to || rv !== 8'(1 << e)) begin errors++; $display("FAIL en_drop_release got=%h exp=%h", rv, 8'(1 << e)); end
    DataValid = 8'hFF;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (xfer_req) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL en_blocked got=%0d req cycles exp=0", seen); end
    sched_en = 1'b1;
    exp_q.push_back(1);
    do_grant(1, 1, 1'b0, 1'b0, 16'h0, b, base, rv, to);
    e = exp_q.pop_front();
    checks++; if (to || b !== 3'(e)) begin errors++; $display("FAIL en_resume got=%0d exp=%0d", b, e); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] b; logic [31:0] base; logic [7:0] rv; bit to; int e; logic [7:0] rv_acc;
    apply_reset();
    msi_enable = 1'b1;
    DataValid = 8'h08;
    tick();
    checks++; if (xfer_req !== 1'b1 || xfer_bank !== 3'd3) begin errors++; $display("FAIL rst_setup req=%b bank=%0d exp=1/3", xfer_req, xfer_bank); end
    xfer_ack = 1'b1;
    tick();
    xfer_ack = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (xfer_req !== 1'b0 || busy !== 1'b0 || xfer_bank !== 3'd0 || xfer_base !== 32'd0) begin
      errors++; $display("FAIL rst_async req=%b busy=%b bank=%0d base=%0d exp=all 0", xfer_req, busy, xfer_bank, xfer_base); end
    rv_acc = RamValid;
    xfer_done = 1'b1;
    tick();
    rv_acc = rv_acc | RamValid;
    xfer_done = 1'b0;
    tick();
    rv_acc = rv_acc | RamValid;
    checks++; if (rv_acc !== 8'h00 || usr_irq_req !== 16'h0000) begin errors++; $display("FAIL rst_no_release rv=%h irq=%h exp=00/0000", rv_acc, usr_irq_req); end
    rst_n = 1'b1;
    DataValid = 8'h81;
    exp_q.push_back(0);
    do_grant(1, 1, 1'b0, 1'b0, 16'h0, b, base, rv, to);
    e = exp_q.pop_front();
    checks++; if (to || b !== 3'(e)) begin errors++; $display("FAIL rst_priority got=%0d exp=%0d", b, e); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_vector_fold();
    test_same_cycle();
    test_sched_en();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
